seat_lookup_reader: RTL and testbench

SEAT_LOOKUP_READER -- requirements
Module: seat_lookup_reader

---
 rtl/seat_lookup_reader.sv | 203 ++++++++++++++++++++
 tb/tb_seat_lookup_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seat_lookup_reader.sv
// rtl/seat_lookup_reader.sv - seat table query engine answering by-seat and by-student lookups
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : query handshake; req_ready is high only while idle
//   req_mode              : 0 = read one seat, 1 = search the table for a student
//   req_seat_no           : seat to read (mode 0)
//   req_student_no        : student to search for (mode 1)
//   cur_time              : current Time count, used for elapsed-time reporting
//   mem_rd_en/mem_rd_addr : seat table read port, data returns one cycle later
//   mem_rd_student_no,
//   mem_rd_seat_state,
//   mem_rd_time           : seat table read data
//   rsp_valid/rsp_ready   : response handshake; fields hold while rsp_ready is low
//   rsp_found, rsp_seat_no, rsp_student_no, rsp_seat_state,
//   rsp_elapsed, rsp_expired : response fields
module seat_lookup_reader #(
    parameter int          NUM_SEATS  = 32,
    parameter logic [10:0] AWAY_LIMIT = 11'd30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mode,
    input  logic [4:0]  req_seat_no,
    input  logic [31:0] req_student_no,
    input  logic [10:0] cur_time,
    output logic        mem_rd_en,
    output logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_student_no,
    input  logic [1:0]  mem_rd_seat_state,
    input  logic [10:0] mem_rd_time,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_found,
    output logic [4:0]  rsp_seat_no,
    output logic [31:0] rsp_student_no,
    output logic [1:0]  rsp_seat_state,
    output logic [10:0] rsp_elapsed,
    output logic        rsp_expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEAT_RD = 2'd1,
        SCAN    = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [4:0] LAST_ADDR  = 5'(NUM_SEATS - 1);
    localparam logic [5:0] SEAT_COUNT = 6'(NUM_SEATS);

    state_t state;
    state_t state_next;

    // rd_pend marks that the table data on mem_rd_* belongs to a read issued
    // last cycle; scan_addr is the seat that data came from.
    logic        rd_pend;
    logic        rd_pend_d;
    logic [4:0]  scan_addr;
    logic [4:0]  scan_addr_d;
    logic [31:0] student_q;
    logic [31:0] student_d;
    logic        mem_rd_en_d;
    logic [4:0]  mem_rd_addr_d;

    logic        rsp_found_d;
    logic [4:0]  rsp_seat_no_d;
    logic [31:0] rsp_student_no_d;
    logic [1:0]  rsp_seat_state_d;
    logic [10:0] rsp_elapsed_d;
    logic        rsp_expired_d;

    logic [10:0] elapsed_now;
    logic        entry_used;
    logic        entry_away_late;
    logic        entry_hit;
    logic        seat_invalid;

    // Modulo-2048 subtraction makes Time wrap-around come out right.
    assign elapsed_now     = cur_time - mem_rd_time;
    assign entry_used      = (mem_rd_seat_state != 2'd0);
    assign entry_away_late = (mem_rd_seat_state == 2'd1) && (elapsed_now > AWAY_LIMIT);
    assign entry_hit       = entry_used && (mem_rd_student_no == student_q);
    assign seat_invalid    = ({1'b0, req_seat_no} >= SEAT_COUNT);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem_rd_en      <= 1'b0;
            mem_rd_addr    <= 5'd0;
            rd_pend        <= 1'b0;
            scan_addr      <= 5'd0;
            student_q      <= 32'd0;
            rsp_found      <= 1'b0;
            rsp_seat_no    <= 5'd0;
            rsp_student_no <= 32'd0;
            rsp_seat_state <= 2'd0;
            rsp_elapsed    <= 11'd0;
            rsp_expired    <= 1'b0;
        end else begin
            state          <= state_next;
            mem_rd_en      <= mem_rd_en_d;
            mem_rd_addr    <= mem_rd_addr_d;
            rd_pend        <= rd_pend_d;
            scan_addr      <= scan_addr_d;
            student_q      <= student_d;
            rsp_found      <= rsp_found_d;
            rsp_seat_no    <= rsp_seat_no_d;
            rsp_student_no <= rsp_student_no_d;
            rsp_seat_state <= rsp_seat_state_d;
            rsp_elapsed    <= rsp_elapsed_d;
            rsp_expired    <= rsp_expired_d;
        end
    end

    always_comb begin
        state_next       = state;
        mem_rd_en_d      = 1'b0;
        mem_rd_addr_d    = mem_rd_addr;
        rd_pend_d        = mem_rd_en;
        scan_addr_d      = mem_rd_en ? mem_rd_addr : scan_addr;
        student_d        = student_q;
        rsp_found_d      = rsp_found;
        rsp_seat_no_d    = rsp_seat_no;
        rsp_student_no_d = rsp_student_no;
        rsp_seat_state_d = rsp_seat_state;
        rsp_elapsed_d    = rsp_elapsed;
        rsp_expired_d    = rsp_expired;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    student_d        = req_student_no;
                    rsp_found_d      = 1'b0;
                    rsp_seat_no_d    = 5'd0;
                    rsp_student_no_d = 32'd0;
                    rsp_seat_state_d = 2'd0;
                    rsp_elapsed_d    = 11'd0;
                    rsp_expired_d    = 1'b0;
                    if (req_mode) begin
                        state_next    = SCAN;
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = 5'd0;
                    end else if (seat_invalid) begin
                        // Out-of-range seat: answer "not found" without touching the table.
                        state_next = RESP;
                    end else begin
                        state_next    = SEAT_RD;
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = req_seat_no;
                    end
                end
            end

            SEAT_RD: begin
                // First cycle issues the read, second cycle sees the data.
                if (rd_pend) begin
                    state_next       = RESP;
                    rsp_found_d      = entry_used;
                    rsp_seat_no_d    = scan_addr;
                    rsp_student_no_d = mem_rd_student_no;
                    rsp_seat_state_d = mem_rd_seat_state;
                    rsp_elapsed_d    = elapsed_now;
                    rsp_expired_d    = entry_used && entry_away_late;
                end
            end

            SCAN: begin
                // Reads stream one per cycle while the previous entry is compared.
                if (rd_pend && entry_hit) begin
                    state_next       = RESP;
                    rsp_found_d      = 1'b1;
                    rsp_seat_no_d    = scan_addr;
                    rsp_student_no_d = mem_rd_student_no;
                    rsp_seat_state_d = mem_rd_seat_state;
                    rsp_elapsed_d    = elapsed_now;
                    rsp_expired_d    = entry_away_late;
                end else if (rd_pend && (scan_addr == LAST_ADDR)) begin
                    state_next = RESP;
                end else if (mem_rd_en && (mem_rd_addr != LAST_ADDR)) begin
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = mem_rd_addr + 5'd1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seat_lookup_reader.sv
// tb/tb_seat_lookup_reader.sv - randomized self-checking bench with a table-search reference model
module tb_seat_lookup_reader;

    localparam int          N     = 32;
    localparam logic [10:0] LIMIT = 11'd30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [4:0]  req_seat_no;
    logic [31:0] req_student_no;
    logic [10:0] cur_time;
    logic        mem_rd_en;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_rd_student_no;
    logic [1:0]  mem_rd_seat_state;
    logic [10:0] mem_rd_time;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_found;
    logic [4:0]  rsp_seat_no;
    logic [31:0] rsp_student_no;
    logic [1:0]  rsp_seat_state;
    logic [10:0] rsp_elapsed;
    logic        rsp_expired;

    seat_lookup_reader #(.NUM_SEATS(N), .AWAY_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_seat_no(req_seat_no), .req_student_no(req_student_no), .cur_time(cur_time),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_student_no(mem_rd_student_no), .mem_rd_seat_state(mem_rd_seat_state),
        .mem_rd_time(mem_rd_time),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_found(rsp_found),
        .rsp_seat_no(rsp_seat_no), .rsp_student_no(rsp_student_no),
        .rsp_seat_state(rsp_seat_state), .rsp_elapsed(rsp_elapsed), .rsp_expired(rsp_expired)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [31:0] t_stu [N];
    logic [1:0]  t_st  [N];
    logic [10:0] t_tm  [N];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_student_no <= t_stu[mem_rd_addr];
            mem_rd_seat_state <= t_st[mem_rd_addr];
            mem_rd_time       <= t_tm[mem_rd_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of the query in flight.
    bit          q_active = 1'b0;
    int          acc_edge;
    int          done_edge;
    bit          e_mode;
    int          e_lat;
    int          e_last;
    logic [31:0] e_found, e_seat, e_stu, e_state, e_el, e_exp;

    function automatic void model(input bit mode, input logic [4:0] seat,
                                  input logic [31:0] stu, input logic [10:0] tm);
        int idx;
        logic [10:0] el;
        e_mode  = mode;
        e_found = 0; e_seat = 0; e_stu = 0; e_state = 0; e_el = 0; e_exp = 0;
        idx = -1;
        if (!mode) begin
            if (int'(seat) >= N) begin
                e_lat  = 1;
                e_last = -1;
                return;
            end
            idx    = int'(seat);
            e_lat  = 2;
            e_last = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (idx < 0 && t_st[i] != 2'd0 && t_stu[i] == stu) idx = i;
            if (idx < 0) begin
                e_lat  = N + 1;
                e_last = N - 1;
                return;
            end
            e_lat  = idx + 2;
            e_last = idx;
        end
        el      = tm - t_tm[idx];
        e_found = (t_st[idx] != 2'd0) ? 1 : 0;
        e_seat  = idx;
        e_stu   = t_stu[idx];
        e_state = t_st[idx];
        e_el    = el;
        e_exp   = (e_found == 1 && t_st[idx] == 2'd1 && el > LIMIT) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        int n;
        if (rst_n === 1'b1) begin
            if (q_active && edge_cnt >= acc_edge) begin
                n = edge_cnt - acc_edge;
                if (done_edge >= 0 && edge_cnt >= done_edge) begin
                    chk("rsp_valid_after_consume", rsp_valid, 0);
                    chk("req_ready_after_consume", req_ready, 1);
                end else begin
                    chk("req_ready_busy", req_ready, 0);
                    if (n >= e_lat) begin
                        chk("rsp_valid", rsp_valid, 1);
                        chk("mem_rd_en_resp", mem_rd_en, 0);
                        chk("rsp_found", rsp_found, e_found);
                        chk("rsp_seat_no", rsp_seat_no, e_seat);
                        chk("rsp_student_no", rsp_student_no, e_stu);
                        chk("rsp_seat_state", rsp_seat_state, e_state);
                        chk("rsp_elapsed", rsp_elapsed, e_el);
                        chk("rsp_expired", rsp_expired, e_exp);
                    end else begin
                        chk("rsp_valid_early", rsp_valid, 0);
                        if (e_mode && n <= e_last) begin
                            chk("scan_rd_en", mem_rd_en, 1);
                            chk("scan_rd_addr", mem_rd_addr, 32'(n));
                        end else if (!e_mode && n == 0) begin
                            chk("seat_rd_en", mem_rd_en, 1);
                            chk("seat_rd_addr", mem_rd_addr, e_seat);
                        end else if (!e_mode && n == 1) begin
                            chk("seat_rd_single", mem_rd_en, 0);
                        end
                    end
                end
            end else if (!q_active) begin
                chk("idle_req_ready", req_ready, 1);
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_mem_rd_en", mem_rd_en, 0);
            end
        end
    end

    task automatic run_query(input bit mode, input logic [4:0] seat, input logic [31:0] stu,
                             input logic [10:0] tm, input int hold, output int lat,
                             output logic [31:0] r_found, output logic [31:0] r_seat,
                             output logic [31:0] r_stu, output logic [31:0] r_state,
                             output logic [31:0] r_el, output logic [31:0] r_exp);
        int cnt;
        lat = -1;
        r_found = '1; r_seat = '1; r_stu = '1; r_state = '1; r_el = '1; r_exp = '1;
        @(negedge clk); #1;
        req_mode       = mode;
        req_seat_no    = seat;
        req_student_no = stu;
        cur_time       = tm;
        req_valid      = 1'b1;
        model(mode, seat, stu, tm);
        chk("req_ready_before_req", req_ready, 1);
        acc_edge  = edge_cnt + 1;
        done_edge = -1;
        q_active  = 1'b1;
        @(negedge clk); #1;
        req_valid      = 1'b0;
        req_seat_no    = 5'($urandom);
        req_student_no = $urandom;
        req_mode       = 1'($urandom);
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin
            @(negedge clk); #1;
            cnt++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            q_active = 1'b0;
            return;
        end
        lat     = edge_cnt - acc_edge;
        r_found = rsp_found;  r_seat = rsp_seat_no;    r_stu = rsp_student_no;
        r_state = rsp_seat_state; r_el = rsp_elapsed;  r_exp = rsp_expired;
        repeat (hold) begin
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        done_edge = edge_cnt + 1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        q_active  = 1'b0;
    endtask

    int          lat;
    logic [31:0] f, s, st, stt, el, ex;
    logic [31:0] pool [6];
    int          cnt;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_seat_no = 5'd0;
        req_student_no = 32'd0; cur_time = 11'd0; rsp_ready = 1'b0;
        mem_rd_student_no = 32'd0; mem_rd_seat_state = 2'd0; mem_rd_time = 11'd0;
        for (int i = 0; i < N; i++) begin
            t_stu[i] = 32'd0; t_st[i] = 2'd0; t_tm[i] = 11'd0;
        end
        t_stu[1] = 32'd201819186; t_st[1] = 2'd2; t_tm[1] = 11'd10;
        t_stu[2] = 32'd201912352; t_st[2] = 2'd1; t_tm[2] = 11'd40;
        t_stu[5] = 32'd555;       t_st[5] = 2'd1; t_tm[5] = 11'd2040;
        t_stu[7] = 32'd777;       t_st[7] = 2'd0; t_tm[7] = 11'd3;

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_mem_rd_en", mem_rd_en, 0);
        chk("reset_mem_rd_addr", mem_rd_addr, 0);
        chk("reset_rsp_fields", {rsp_found, rsp_seat_no, rsp_seat_state, rsp_expired}, 0);
        chk("reset_rsp_student", rsp_student_no, 0);
        chk("reset_rsp_elapsed", rsp_elapsed, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", req_ready, 1);

        run_query(1'b0, 5'd1, 32'd0, 11'd50, 0, lat, f, s, st, stt, el, ex);
        chk("lit_seat1_lat", lat, 2);
        chk("lit_seat1_found", f, 1);
        chk("lit_seat1_student", st, 201819186);
        chk("lit_seat1_state", stt, 2);
        chk("lit_seat1_elapsed", el, 40);
        chk("lit_seat1_expired", ex, 0);

        run_query(1'b1, 5'd0, 32'd201912352, 11'd80, 1, lat, f, s, st, stt, el, ex);
        chk("lit_stu_lat", lat, 4);
        chk("lit_stu_seat", s, 2);
        chk("lit_stu_elapsed", el, 40);
        chk("lit_stu_expired", ex, 1);

        run_query(1'b1, 5'd0, 32'd201912352, 11'd70, 0, lat, f, s, st, stt, el, ex);
        chk("lit_stu70_elapsed", el, 30);
        chk("lit_stu70_expired", ex, 0);

        run_query(1'b0, 5'd5, 32'd0, 11'd10, 0, lat, f, s, st, stt, el, ex);
        chk("lit_wrap_elapsed", el, 18);
        chk("lit_wrap_expired", ex, 0);

        run_query(1'b1, 5'd0, 32'd2019123179, 11'd5, 0, lat, f, s, st, stt, el, ex);
        chk("lit_absent_lat", lat, 33);
        chk("lit_absent_found", f, 0);
        chk("lit_absent_fields", s | st | stt | el | ex, 0);

        run_query(1'b0, 5'd7, 32'd0, 11'd9, 0, lat, f, s, st, stt, el, ex);
        chk("lit_empty_found", f, 0);

        run_query(1'b0, 5'd1, 32'd0, 11'd60, 10, lat, f, s, st, stt, el, ex);
        chk("lit_hold_elapsed", el, 50);

        // Abort a scan with reset once it reaches address 12.
        @(negedge clk); #1;
        req_mode = 1'b1; req_student_no = 32'd2019123179; cur_time = 11'd0; req_valid = 1'b1;
        model(1'b1, 5'd0, 32'd2019123179, 11'd0);
        acc_edge = edge_cnt + 1; done_edge = -1; q_active = 1'b1;
        @(negedge clk); #1;
        req_valid = 1'b0;
        cnt = 0;
        while (!(mem_rd_en && mem_rd_addr == 5'd12) && cnt < 50) begin
            @(negedge clk); #1;
            cnt++;
        end
        chk("abort_reached_addr12", mem_rd_addr, 12);
        rst_n = 1'b0; q_active = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_mem_rd_en", mem_rd_en, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_mem_rd_addr", mem_rd_addr, 0);
        repeat (40) @(negedge clk);

        for (int it = 0; it < 48; it++) begin
            logic [4:0]  rs;
            logic [31:0] ru;
            logic [10:0] rt;
            if (it % 8 == 0) begin
                for (int p = 0; p < 6; p++) pool[p] = $urandom;
                for (int i = 0; i < N; i++) begin
                    t_stu[i] = pool[$urandom_range(0, 5)];
                    t_st[i]  = 2'($urandom_range(0, 3));
                    t_tm[i]  = 11'($urandom);
                end
            end
            rs = 5'($urandom);
            ru = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
            case ($urandom_range(0, 2))
                0:       rt = t_tm[rs] + LIMIT;
                1:       rt = t_tm[rs] + LIMIT + 11'd1;
                default: rt = 11'($urandom);
            endcase
            run_query(1'($urandom), rs, ru, rt, $urandom_range(0, 3), lat, f, s, st, stt, el, ex);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
